hr_meas_ctrl: RTL and testbench
===============================

// Module: hr_meas_ctrl
// PURPOSE
//   Measurement sequencer for the heart-rate datapath.
//   - Drives the pulse counter's clear / en_count / en_cap strobes through one fixed time window.
//   - Reads the captured pulse count, scales it to beats-per-minute and compares it with set_pulso.
//   - Raises a sticky alarm. Sits between the user inputs (start, cls, set_pulso) and the counter/display datapath.
// PARAMETERS
//   TICK_DIV  10_000_000  clk cycles per 1 s tick (10 MHz board clock)
//   WIN_SEC   15          window length in seconds; 60 % WIN_SEC must be 0 (elaboration check)
//   MIN_BPM   40          low-rate alarm threshold; 0 disables the low alarm
//   (localparam BPM_MULT = 60/WIN_SEC; default 4)
// PORTS
//   clk        in   1  clock
//   rst        in   1  synchronous reset, active high
//   start      in   1  rising edge starts a measurement; held high = continuous measurements
//   cls        in   1  synchronous clear: abort, clear bpm and alarm
//   set_pulso  in   8  high-rate alarm threshold, bpm
//   cnt_in     in   8  pulse count from datapath capture register
//   clear      out  1  one-cycle datapath counter clear
//   en_count   out  1  counter enable, high for the whole window
//   en_cap     out  1  one-cycle capture strobe at window end
//   bpm        out  8  last measured rate, saturated at 255
//   bpm_valid  out  1  one-cycle pulse when bpm updates
//   alarm      out  1  sticky: bpm > set_pulso, or bpm < MIN_BPM
//   busy       out  1  high in any state except IDLE
//   state      out  3  current FSM state (encoding from package)
// BEHAVIOUR
//   Reset
//     - All outputs 0; state = IDLE; start edge register = 0.
//   Start edge
//     - start_q registers start; edge = start & ~start_q. Edges outside IDLE are ignored.
//   FSM (Moore strobes)
//     - IDLE: strobes 0. On edge -> CLR.
//     - CLR: clear=1 for exactly 1 cycle. Window timer zeroed -> COUNT.
//     - COUNT: en_count=1. Timer prescaler 0..TICK_DIV-1, seconds 0..WIN_SEC-1.
//       After exactly TICK_DIV*WIN_SEC COUNT cycles -> CAP.
//     - CAP: en_cap=1 for 1 cycle -> EVAL.
//     - EVAL: sample cnt_in (valid the cycle after en_cap). Then:
//       - prod = cnt_in*BPM_MULT (16-bit); bpm = prod>255 ? 255 : prod[7:0].
//       - bpm_valid=1 (registered, asserted the cycle after EVAL).
//       - alarm |= (bpm_new > set_pulso) | (MIN_BPM!=0 & bpm_new < MIN_BPM).
//       - Next state: start==1 -> CLR (continuous); else -> IDLE.
//   Alarm and bpm
//     - alarm is never cleared by a later normal reading; only cls or rst clears it.
//     - bpm holds between measurements.
//   cls (priority over start and all transitions, any state)
//     - Next cycle: state=IDLE, strobes 0, bpm=0, alarm=0.
//     - Pending EVAL result discarded, bpm_valid stays 0.
//   Boundaries
//     - rst mid-window behaves like cls.
//     - cnt_in=0 -> bpm=0 (low alarm if enabled).
//     - set_pulso=255 -> high alarm impossible.
//     - Comparison is strict on both thresholds.
//     - set_pulso is sampled only in EVAL.
// STRUCTURE
//   Package hr_ctrl_pkg
//     - state encoding: IDLE=0, CLR=1, COUNT=2, CAP=3, EVAL=4.
//     - BPM_W=8.
//   Sub-module hr_window_timer (clk, rst, restart, run -> done)
//     - prescaler plus seconds counter, widths via $clog2.
//     - done is a 1-cycle pulse on the last window cycle.
//   FSM, scaling/saturation and alarm logic stay in hr_meas_ctrl.
// TESTING (TICK_DIV=4, WIN_SEC=15 -> 60-cycle window, BPM_MULT=4, MIN_BPM=40)
//   - rst 3 cycles -> all outputs 0, state=IDLE; start held low 100 cycles -> no strobes.
//   - start 0->1, set_pulso=100, cnt_in=18 -> clear 1 cycle, en_count exactly 60 cycles, en_cap 1 cycle,
//     then bpm=72, bpm_valid 1 cycle, alarm=0, IDLE.
//   - cnt_in=30 -> bpm=120, alarm=1; next run with cnt_in=18 -> alarm stays 1;
//     cls -> alarm=0, bpm=0 next cycle.
//   - cnt_in=70 -> bpm=255 (saturated), alarm=1; cnt_in=5 -> bpm=20, alarm=1 (low).
//   - start held high -> back-to-back windows CLR,COUNT(60),CAP,EVAL repeating;
//     extra start edges while busy ignored.
//   - cls on cycle 30 of COUNT -> IDLE next cycle, en_count drops, no en_cap/bpm_valid;
//     same with rst.

Source files
------------

// File: rtl/hr_ctrl_pkg.sv
// Shared types and helpers for the heart-rate measurement controller.
package hr_ctrl_pkg;

  localparam int BPM_W = 8;

  // Sequencer states; the numeric values are visible on the state port.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    COUNT = 3'd2,
    CAP   = 3'd3,
    EVAL  = 3'd4
  } state_t;

  // Clamp a scaled pulse count into the 8-bit rate range.
  function automatic logic [BPM_W-1:0] sat_bpm(input logic [15:0] prod);
    return (prod > 16'd255) ? {BPM_W{1'b1}} : prod[BPM_W-1:0];
  endfunction

endpackage

// File: rtl/hr_window_timer.sv
// Fixed-length measurement window: prescaler to 1 s ticks, then a seconds
// counter. done pulses on the last run cycle of the window.
module hr_window_timer #(
  parameter int TICK_DIV = 10_000_000,
  parameter int WIN_SEC  = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic run,
  output logic done
);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SEC_W = (WIN_SEC > 1) ? $clog2(WIN_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(WIN_SEC - 1);

  logic [PRE_W-1:0] pre;
  logic [SEC_W-1:0] sec;
  logic             tick;

  assign tick = run && (pre == PRE_LAST);
  assign done = tick && (sec == SEC_LAST);

  // Prescaler wraps each second; seconds wrap at window end so a missed
  // restart still yields correctly sized windows.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      pre <= '0;
      sec <= '0;
    end else if (run) begin
      if (tick) begin
        pre <= '0;
        sec <= (sec == SEC_LAST) ? '0 : sec + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hr_meas_ctrl.sv
// Heart-rate measurement sequencer: runs one counting window on the pulse
// datapath, scales the captured count to bpm and keeps a sticky rate alarm.
module hr_meas_ctrl
  import hr_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 10_000_000,
  parameter int WIN_SEC  = 15,
  parameter int MIN_BPM  = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cls,
  input  logic [BPM_W-1:0] set_pulso,
  input  logic [7:0]       cnt_in,
  output logic             clear,
  output logic             en_count,
  output logic             en_cap,
  output logic [BPM_W-1:0] bpm,
  output logic             bpm_valid,
  output logic             alarm,
  output logic             busy,
  output logic [2:0]       state
);
  localparam int               BPM_MULT = 60 / WIN_SEC;
  localparam logic [15:0]      MULT_W   = 16'(BPM_MULT);
  localparam logic [BPM_W-1:0] MIN_B    = BPM_W'(MIN_BPM);
  localparam bit               LOW_EN   = (MIN_BPM != 0);

  // The window must be a whole fraction of a minute for integer scaling.
  generate
    if ((60 % WIN_SEC) != 0) begin : g_bad_win
      $error("hr_meas_ctrl: WIN_SEC must divide 60");
    end
  endgenerate

  state_t           cur, nxt;
  logic             start_q;
  logic             start_edge;
  logic             win_done;
  logic [15:0]      prod;
  logic [BPM_W-1:0] bpm_new;
  logic             hi_flag;
  logic             lo_flag;

  assign start_edge = start & ~start_q;

  hr_window_timer #(
    .TICK_DIV (TICK_DIV),
    .WIN_SEC  (WIN_SEC)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (cur == CLR),
    .run     (cur == COUNT),
    .done    (win_done)
  );

  // Rate arithmetic on the captured count; only consumed while in EVAL.
  assign prod    = {8'd0, cnt_in} * MULT_W;
  assign bpm_new = sat_bpm(prod);
  assign hi_flag = (bpm_new > set_pulso);
  assign lo_flag = LOW_EN && (bpm_new < MIN_B);

  // Moore strobes decoded straight from the state register.
  assign clear    = (cur == CLR);
  assign en_count = (cur == COUNT);
  assign en_cap   = (cur == CAP);
  assign busy     = (cur != IDLE);
  assign state    = cur;

  // Start edge detector and state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b0;
      cur     <= IDLE;
    end else begin
      start_q <= start;
      cur     <= nxt;
    end
  end

  // Next-state logic; cls overrides every transition.
  always_comb begin
    nxt = cur;
    if (cls) begin
      nxt = IDLE;
    end else begin
      case (cur)
        IDLE:    if (start_edge) nxt = CLR;
        CLR:     nxt = COUNT;
        COUNT:   if (win_done) nxt = CAP;
        CAP:     nxt = EVAL;
        EVAL:    nxt = start ? CLR : IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  // Result registers: bpm holds between runs, alarm is sticky until cls/rst,
  // and a cls in EVAL drops that run's result entirely.
  always_ff @(posedge clk) begin
    if (rst || cls) begin
      bpm       <= '0;
      bpm_valid <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      bpm_valid <= (cur == EVAL);
      if (cur == EVAL) begin
        bpm   <= bpm_new;
        alarm <= alarm | hi_flag | lo_flag;
      end
    end
  end

endmodule

// File: tb/tb_hr_meas_ctrl.sv
// Self-checking bench for hr_meas_ctrl with a 60-cycle window.
module tb_hr_meas_ctrl;
  import hr_ctrl_pkg::*;

  localparam int TD   = 4;
  localparam int WS   = 15;
  localparam int MINB = 40;
  localparam int MULT = 60 / WS;
  localparam int WIN  = TD * WS;

  logic       clk = 1'b0;
  logic       rst, start, cls;
  logic [7:0] set_pulso, cnt_in;
  logic       clear, en_count, en_cap, bpm_valid, alarm, busy;
  logic [7:0] bpm;
  logic [2:0] state;

  always #5 clk = ~clk;

  hr_meas_ctrl #(.TICK_DIV(TD), .WIN_SEC(WS), .MIN_BPM(MINB)) dut (
    .clk(clk), .rst(rst), .start(start), .cls(cls),
    .set_pulso(set_pulso), .cnt_in(cnt_in),
    .clear(clear), .en_count(en_count), .en_cap(en_cap),
    .bpm(bpm), .bpm_valid(bpm_valid), .alarm(alarm),
    .busy(busy), .state(state)
  );

  int errors = 0;
  int checks = 0;
  int n_clr, n_cnt, n_cap, n_val, last_val, stepno;
  logic model_alarm;

  typedef struct {
    logic [7:0] c;
    logic [7:0] sp;
    bit         cls_after;
    logic [7:0] e_bpm;
    logic       e_alarm;
  } vec_t;
  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    n_clr = 0; n_cnt = 0; n_cap = 0; n_val = 0; last_val = -1; stepno = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    stepno++;
    if (clear)    n_clr++;
    if (en_count) n_cnt++;
    if (en_cap)   n_cap++;
    if (bpm_valid) begin n_val++; last_val = stepno; end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reference: rate = count * 60/window, clamped to 255; alarm on strict
  // over-threshold or strict under the low limit.
  function automatic int ref_bpm(input int c);
    int p;
    p = c * MULT;
    return (p > 255) ? 255 : p;
  endfunction

  function automatic logic ref_flag(input int b, input int sp);
    return (b > sp) || ((MINB != 0) && (b < MINB));
  endfunction

  // One single-shot measurement, checking the strobe timing on the way.
  task automatic measure(input logic [7:0] c, input logic [7:0] sp, input string tag);
    cnt_in = c; set_pulso = sp;
    clr_counts();
    start = 1'b1; step(); start = 1'b0;
    cycles(69);
    chk({tag, " clear"},    n_clr, 1);
    chk({tag, " en_count"}, n_cnt, WIN);
    chk({tag, " en_cap"},   n_cap, 1);
    chk({tag, " valid"},    n_val, 1);
    chk({tag, " valid_at"}, last_val, WIN + 4);
    chk({tag, " idle"},     state, 0);
  endtask

  task automatic do_cls(input string tag);
    cls = 1'b1; step(); cls = 1'b0;
    chk({tag, " cls bpm"},   bpm, 0);
    chk({tag, " cls alarm"}, alarm, 0);
    chk({tag, " cls state"}, state, 0);
    chk({tag, " cls valid"}, bpm_valid, 0);
  endtask

  initial begin
    vt[0]  = '{8'd18, 8'd100, 1'b0, 8'd72,  1'b0};
    vt[1]  = '{8'd30, 8'd100, 1'b0, 8'd120, 1'b1};
    vt[2]  = '{8'd18, 8'd100, 1'b1, 8'd72,  1'b1};
    vt[3]  = '{8'd70, 8'd100, 1'b1, 8'd255, 1'b1};
    vt[4]  = '{8'd5,  8'd100, 1'b1, 8'd20,  1'b1};
    vt[5]  = '{8'd0,  8'd255, 1'b1, 8'd0,   1'b1};
    vt[6]  = '{8'd63, 8'd255, 1'b0, 8'd252, 1'b0};
    vt[7]  = '{8'd64, 8'd255, 1'b0, 8'd255, 1'b0};
    vt[8]  = '{8'd25, 8'd100, 1'b0, 8'd100, 1'b0};
    vt[9]  = '{8'd10, 8'd100, 1'b0, 8'd40,  1'b0};
    vt[10] = '{8'd9,  8'd100, 1'b1, 8'd36,  1'b1};

    rst = 1'b1; start = 1'b0; cls = 1'b0; set_pulso = 8'd0; cnt_in = 8'd0;
    cycles(3);
    chk("rst clear", clear, 0);
    chk("rst en_count", en_count, 0);
    chk("rst en_cap", en_cap, 0);
    chk("rst bpm", bpm, 0);
    chk("rst bpm_valid", bpm_valid, 0);
    chk("rst alarm", alarm, 0);
    chk("rst busy", busy, 0);
    chk("rst state", state, 0);
    rst = 1'b0;
    clr_counts();
    cycles(100);
    chk("idle strobes", n_clr + n_cnt + n_cap + n_val, 0);
    chk("idle busy", busy, 0);

    // Table vectors.
    for (int i = 0; i < 11; i++) begin
      measure(vt[i].c, vt[i].sp, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d bpm", i), bpm, vt[i].e_bpm);
      chk($sformatf("vec%0d alarm", i), alarm, vt[i].e_alarm);
      if (vt[i].cls_after) do_cls($sformatf("vec%0d", i));
    end
    do_cls("pre_cont");

    // Continuous mode with a spurious start edge inside COUNT.
    cnt_in = 8'd18; set_pulso = 8'd100;
    clr_counts();
    start = 1'b1; step();
    cycles(8);
    start = 1'b0; step();
    start = 1'b1;
    cycles(120);
    chk("cont clear", n_clr, 3);
    chk("cont en_cap", n_cap, 2);
    chk("cont valid", n_val, 2);
    chk("cont last_valid", last_val, 127);
    chk("cont en_count", n_cnt, 123);
    chk("cont bpm", bpm, 72);
    chk("cont alarm", alarm, 0);
    cls = 1'b1; step(); cls = 1'b0;
    cycles(5);
    chk("cont held idle", state, 0);
    chk("cont held busy", busy, 0);
    start = 1'b0; step();

    // cls then rst at COUNT cycle 30.
    for (int k = 0; k < 2; k++) begin
      measure(8'd30, 8'd100, "pre_abort");
      clr_counts();
      start = 1'b1; step(); start = 1'b0;
      cycles(30);
      chk("abort in count", state, 2);
      if (k == 0) cls = 1'b1; else rst = 1'b1;
      step();
      cls = 1'b0; rst = 1'b0;
      chk("abort state", state, 0);
      chk("abort en_count", en_count, 0);
      chk("abort bpm", bpm, 0);
      chk("abort alarm", alarm, 0);
      clr_counts();
      cycles(70);
      chk("abort no strobes", n_clr + n_cnt + n_cap + n_val, 0);
    end

    // cls in EVAL discards the pending result.
    measure(8'd18, 8'd100, "pre_eval");
    cnt_in = 8'd30;
    clr_counts();
    start = 1'b1; step(); start = 1'b0;
    cycles(62);
    chk("eval reached", state, 4);
    cls = 1'b1; step(); cls = 1'b0;
    chk("eval cls valid", bpm_valid, 0);
    chk("eval cls bpm", bpm, 0);
    chk("eval cls alarm", alarm, 0);
    chk("eval cls state", state, 0);

    // set_pulso only matters at EVAL.
    cnt_in = 8'd18; set_pulso = 8'd0;
    clr_counts();
    start = 1'b1; step(); start = 1'b0;
    cycles(61);
    set_pulso = 8'd100;
    cycles(8);
    chk("late thr bpm", bpm, 72);
    chk("late thr alarm", alarm, 0);

    // Randomized runs against the reference model.
    do_cls("pre_rand");
    model_alarm = 1'b0;
    for (int i = 0; i < 24; i++) begin
      int c, sp, eb;
      c  = $urandom_range(0, 80);
      sp = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) begin
        do_cls($sformatf("rnd%0d", i));
        model_alarm = 1'b0;
      end
      measure(8'(c), 8'(sp), $sformatf("rnd%0d", i));
      eb = ref_bpm(c);
      model_alarm = model_alarm | ref_flag(eb, sp);
      chk($sformatf("rnd%0d bpm c=%0d", i, c), bpm, eb);
      chk($sformatf("rnd%0d alarm c=%0d sp=%0d", i, c, sp), alarm, model_alarm);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
